// File: rtl/cuckoo_pkg.sv
// Shared types, default widths and the key tag extraction helper for the
// two-bank cuckoo hash controller.
package cuckoo_pkg;

    localparam int DEF_WIDTH       = 64;
    localparam int DEF_TAG_WIDTH   = 12;
    localparam int DEF_INDEX_WIDTH = 6;
    localparam int MAX_KEY_WIDTH   = 128;

    typedef enum logic {
        OP_LOOKUP = 1'b0,
        OP_INSERT = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_OK     = 2'd0,
        ST_DUP    = 2'd1,
        ST_FULL   = 2'd2,
        ST_BADKEY = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PROBE_L = 3'd1,
        PROBE_R = 3'd2,
        WRITE   = 3'd3,
        RESP    = 3'd4
    } state_e;

    // Tag lives directly above the bank index bits of the key.
    function automatic logic [MAX_KEY_WIDTH-1:0] key_tag(
        input logic [MAX_KEY_WIDTH-1:0] key,
        input int                       tag_w,
        input int                       idx_w
    );
        logic [MAX_KEY_WIDTH-1:0] mask;
        mask = {MAX_KEY_WIDTH{1'b1}} >> (MAX_KEY_WIDTH - tag_w);
        return (key >> idx_w) & mask;
    endfunction

endpackage

// File: rtl/cuckoo_ctrl_if.sv
// Request/response handshake bundle of the cuckoo controller; the slave
// modport is the controller side, the master modport is the requester side.
interface cuckoo_ctrl_if #(
    parameter int WIDTH = 64
);
    logic             req_valid_i;
    logic             req_ready_o;
    logic             req_op_i;
    logic [WIDTH-1:0] req_key_i;
    logic             rsp_valid_o;
    logic             rsp_ready_i;
    logic             rsp_hit_o;
    logic             rsp_side_o;
    logic [1:0]       rsp_status_o;

    modport master (
        output req_valid_i, req_op_i, req_key_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_hit_o, rsp_side_o, rsp_status_o
    );

    modport slave (
        input  req_valid_i, req_op_i, req_key_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_hit_o, rsp_side_o, rsp_status_o
    );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping; synchronous clear.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] count_o
);
    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != '1)) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
endmodule

// File: rtl/cuckoo_ctrl.sv
// Two-bank cuckoo hash lookup/insert controller. Optional response statistics
// counters are built when CUCKOO_CTRL_STATS_EN is defined.
module cuckoo_ctrl
    import cuckoo_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int TAG_WIDTH   = DEF_TAG_WIDTH,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    cuckoo_ctrl_if.slave         bus,
    output logic                 l_read_o,
    output logic                 l_write_o,
    output logic [WIDTH-1:0]     l_addr_o,
    output logic [WIDTH-1:0]     l_data_o,
    input  logic                 l_hit_i,
    input  logic [TAG_WIDTH-1:0] l_tag_i,
    input  logic                 l_valid_i,
    output logic                 r_read_o,
    output logic                 r_write_o,
    output logic [WIDTH-1:0]     r_addr_o,
    output logic [WIDTH-1:0]     r_data_o,
    input  logic                 r_hit_i,
    input  logic [TAG_WIDTH-1:0] r_tag_i,
    input  logic                 r_valid_i
`ifdef CUCKOO_CTRL_STATS_EN
   ,output logic [31:0]          stat_lookups_o,
    output logic [31:0]          stat_hits_o,
    output logic [31:0]          stat_inserts_o,
    output logic [31:0]          stat_fails_o
`endif
);

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [WIDTH-1:0]       key_q, key_d;
    logic                   l_hit_q, l_hit_d, r_hit_q, r_hit_d;
    logic [TAG_WIDTH-1:0]   l_tag_q, l_tag_d, r_tag_q, r_tag_d;
    logic                   side_q, side_d;
    status_e                status_q, status_d;

    logic l_hit_now, r_hit_now, tag_zero;
    logic req_ready, rsp_valid;

    assign l_hit_now = l_hit_i & l_valid_i;
    assign r_hit_now = r_hit_i & r_valid_i;
    assign tag_zero  = (key_tag(MAX_KEY_WIDTH'(key_q), TAG_WIDTH, INDEX_WIDTH) == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_LOOKUP;
            key_q    <= '0;
            l_hit_q  <= 1'b0;
            r_hit_q  <= 1'b0;
            l_tag_q  <= '0;
            r_tag_q  <= '0;
            side_q   <= 1'b0;
            status_q <= ST_OK;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            key_q    <= key_d;
            l_hit_q  <= l_hit_d;
            r_hit_q  <= r_hit_d;
            l_tag_q  <= l_tag_d;
            r_tag_q  <= r_tag_d;
            side_q   <= side_d;
            status_q <= status_d;
        end
    end

    // Response fields are latched on the transition into RESP so they stay put
    // for however long the consumer stalls.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        key_d    = key_q;
        l_hit_d  = l_hit_q;
        r_hit_d  = r_hit_q;
        l_tag_d  = l_tag_q;
        r_tag_d  = r_tag_q;
        side_d   = side_q;
        status_d = status_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i) begin
                    op_d    = op_e'(bus.req_op_i);
                    key_d   = bus.req_key_i;
                    l_hit_d = 1'b0;
                    r_hit_d = 1'b0;
                    l_tag_d = '0;
                    r_tag_d = '0;
                    state_d = PROBE_L;
                end
            end
            PROBE_L: begin
                l_hit_d = l_hit_now;
                l_tag_d = l_tag_i;
                if (op_q == OP_LOOKUP && l_hit_now) begin
                    side_d   = 1'b0;
                    status_d = ST_OK;
                    state_d  = RESP;
                end else if (op_q == OP_INSERT && tag_zero) begin
                    side_d   = 1'b0;
                    status_d = ST_BADKEY;
                    state_d  = RESP;
                end else begin
                    state_d = PROBE_R;
                end
            end
            PROBE_R: begin
                r_hit_d = r_hit_now;
                r_tag_d = r_tag_i;
                state_d = RESP;
                if (op_q == OP_LOOKUP) begin
                    side_d   = r_hit_now;
                    status_d = ST_OK;
                end else if (l_hit_q || r_hit_now) begin
                    side_d   = ~l_hit_q;
                    status_d = ST_DUP;
                end else if (l_tag_q == '0 || r_tag_i == '0) begin
                    state_d = WRITE;
                end else begin
                    side_d   = 1'b0;
                    status_d = ST_FULL;
                end
            end
            WRITE: begin
                side_d   = (l_tag_q != '0);
                status_d = ST_OK;
                state_d  = RESP;
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are masked by rst so an abandoned request never reaches a bank.
    always_comb begin
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        l_read_o  = 1'b0;
        r_read_o  = 1'b0;
        l_write_o = 1'b0;
        r_write_o = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE:    req_ready = 1'b1;
                PROBE_L: l_read_o  = 1'b1;
                PROBE_R: r_read_o  = 1'b1;
                WRITE: begin
                    l_write_o = (l_tag_q == '0);
                    r_write_o = (l_tag_q != '0) && (r_tag_q == '0);
                end
                RESP:    rsp_valid = 1'b1;
                default: req_ready = 1'b0;
            endcase
        end
    end

    assign bus.req_ready_o  = req_ready;
    assign bus.rsp_valid_o  = rsp_valid;
    assign bus.rsp_hit_o    = (status_q == ST_DUP) || ((op_q == OP_LOOKUP) && (l_hit_q || r_hit_q));
    assign bus.rsp_side_o   = side_q;
    assign bus.rsp_status_o = status_q;

    assign l_addr_o = key_q;
    assign l_data_o = key_q;
    assign r_addr_o = key_q;
    assign r_data_o = key_q;

`ifdef CUCKOO_CTRL_STATS_EN
    logic rsp_fire;
    assign rsp_fire = rsp_valid & bus.rsp_ready_i;

    sat_counter #(.W(32)) u_stat_lookups (
        .clk     (clk),
        .clr_i   (rst),
        .inc_i   (rsp_fire && op_q == OP_LOOKUP),
        .count_o (stat_lookups_o)
    );

    sat_counter #(.W(32)) u_stat_hits (
        .clk     (clk),
        .clr_i   (rst),
        .inc_i   (rsp_fire && op_q == OP_LOOKUP && bus.rsp_hit_o),
        .count_o (stat_hits_o)
    );

    sat_counter #(.W(32)) u_stat_inserts (
        .clk     (clk),
        .clr_i   (rst),
        .inc_i   (rsp_fire && op_q == OP_INSERT),
        .count_o (stat_inserts_o)
    );

    sat_counter #(.W(32)) u_stat_fails (
        .clk     (clk),
        .clr_i   (rst),
        .inc_i   (rsp_fire && (status_q == ST_FULL || status_q == ST_BADKEY)),
        .count_o (stat_fails_o)
    );
`endif

endmodule

// File: tb/tb_cuckoo_ctrl.sv
// Randomized self-checking bench for cuckoo_ctrl: a transaction-level model
// predicts the per-cycle strobe/response trace, one process compares it.
module tb_cuckoo_ctrl;

    typedef struct packed {
        logic        req_ready;
        logic        l_read;
        logic        r_read;
        logic        l_write;
        logic        r_write;
        logic        rsp_valid;
        logic        chk_hit;
        logic        hit;
        logic        chk_side;
        logic        side;
        logic        chk_status;
        logic [1:0]  status;
        logic        chk_key;
        logic [63:0] key;
    } rec_t;

    typedef struct {
        int         lat;
        logic [1:0] status;
        logic       chk_hit;
        logic       hit;
        logic       chk_side;
        logic       side;
        logic       wl;
        logic       wr;
        logic       probe_r;
    } model_t;

    logic        clk;
    logic        rst;
    logic        l_read_o, l_write_o, r_read_o, r_write_o;
    logic [63:0] l_addr_o, l_data_o, r_addr_o, r_data_o;
    logic        l_hit_i, l_valid_i, r_hit_i, r_valid_i;
    logic [11:0] l_tag_i, r_tag_i;
`ifdef CUCKOO_CTRL_STATS_EN
    logic [31:0] stat_lookups_o, stat_hits_o, stat_inserts_o, stat_fails_o;
`endif

    int   checks = 0;
    int   errors = 0;
    int   exp_lookups = 0, exp_hits = 0, exp_inserts = 0, exp_fails = 0;
    rec_t exp_q[$];

    cuckoo_ctrl_if #(.WIDTH(64)) bus ();

    cuckoo_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .l_read_o  (l_read_o),
        .l_write_o (l_write_o),
        .l_addr_o  (l_addr_o),
        .l_data_o  (l_data_o),
        .l_hit_i   (l_hit_i),
        .l_tag_i   (l_tag_i),
        .l_valid_i (l_valid_i),
        .r_read_o  (r_read_o),
        .r_write_o (r_write_o),
        .r_addr_o  (r_addr_o),
        .r_data_o  (r_data_o),
        .r_hit_i   (r_hit_i),
        .r_tag_i   (r_tag_i),
        .r_valid_i (r_valid_i)
`ifdef CUCKOO_CTRL_STATS_EN
       ,.stat_lookups_o (stat_lookups_o),
        .stat_hits_o    (stat_hits_o),
        .stat_inserts_o (stat_inserts_o),
        .stat_fails_o   (stat_fails_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Outcome of one request derived directly from the controller's rules.
    function automatic model_t model(input logic op, input logic [63:0] key,
                                     input logic lh, input logic lv, input logic [11:0] lt,
                                     input logic rh, input logic rv, input logic [11:0] rt);
        model_t m;
        logic        l   = lh & lv;
        logic        r   = rh & rv;
        logic [63:0] tag = (key >> 6) & 64'hFFF;
        m.lat = 3; m.status = 2'd0; m.chk_hit = 1'b0; m.hit = 1'b0;
        m.chk_side = 1'b0; m.side = 1'b0; m.wl = 1'b0; m.wr = 1'b0; m.probe_r = 1'b1;
        if (op == 1'b0) begin
            m.chk_hit = 1'b1;
            if (l) begin
                m.lat = 2; m.probe_r = 1'b0; m.hit = 1'b1; m.chk_side = 1'b1; m.side = 1'b0;
            end else begin
                m.hit = r; m.chk_side = r; m.side = 1'b1;
            end
        end else if (tag == 64'd0) begin
            m.lat = 2; m.probe_r = 1'b0; m.status = 2'd3;
        end else if (l || r) begin
            m.status = 2'd1; m.chk_hit = 1'b1; m.hit = 1'b1; m.chk_side = 1'b1; m.side = !l;
        end else if (lt == 12'd0) begin
            m.lat = 4; m.wl = 1'b1; m.chk_side = 1'b1; m.side = 1'b0;
        end else if (rt == 12'd0) begin
            m.lat = 4; m.wr = 1'b1; m.chk_side = 1'b1; m.side = 1'b1;
        end else begin
            m.status = 2'd2; m.chk_hit = 1'b1; m.hit = 1'b0;
        end
        return m;
    endfunction

    // Single compare process: one trace record per falling edge.
    always @(negedge clk) begin
        rec_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("req_ready", 64'(bus.req_ready_o), 64'(e.req_ready));
            checkOutput("l_read", 64'(l_read_o), 64'(e.l_read));
            checkOutput("r_read", 64'(r_read_o), 64'(e.r_read));
            checkOutput("l_write", 64'(l_write_o), 64'(e.l_write));
            checkOutput("r_write", 64'(r_write_o), 64'(e.r_write));
            checkOutput("rsp_valid", 64'(bus.rsp_valid_o), 64'(e.rsp_valid));
            if (e.chk_hit)    checkOutput("rsp_hit", 64'(bus.rsp_hit_o), 64'(e.hit));
            if (e.chk_side)   checkOutput("rsp_side", 64'(bus.rsp_side_o), 64'(e.side));
            if (e.chk_status) checkOutput("rsp_status", 64'(bus.rsp_status_o), 64'(e.status));
            if (e.chk_key) begin
                checkOutput("l_addr", l_addr_o, e.key);
                checkOutput("l_data", l_data_o, e.key);
                checkOutput("r_addr", r_addr_o, e.key);
                checkOutput("r_data", r_data_o, e.key);
            end
        end
    end

    // Called at posedge+2; returns at posedge+2 after the response handshake.
    task automatic applyStimulus(input logic op, input logic [63:0] key,
                                 input logic lh, input logic lv, input logic [11:0] lt,
                                 input logic rh, input logic rv, input logic [11:0] rt,
                                 input int hold, output model_t m);
        rec_t r;
        m = model(op, key, lh, lv, lt, rh, rv, rt);
        l_hit_i = lh; l_valid_i = lv; l_tag_i = lt;
        r_hit_i = rh; r_valid_i = rv; r_tag_i = rt;
        bus.req_valid_i = 1'b1; bus.req_op_i = op; bus.req_key_i = key;
        r = '0; r.req_ready = 1'b1;
        exp_q.push_back(r);
        r = '0; r.chk_key = 1'b1; r.key = key; r.l_read = 1'b1;
        exp_q.push_back(r);
        if (m.probe_r) begin
            r = '0; r.chk_key = 1'b1; r.key = key; r.r_read = 1'b1;
            exp_q.push_back(r);
        end
        if (m.wl || m.wr) begin
            r = '0; r.chk_key = 1'b1; r.key = key; r.l_write = m.wl; r.r_write = m.wr;
            exp_q.push_back(r);
        end
        for (int h = 0; h <= hold; h++) begin
            r = '0; r.chk_key = 1'b1; r.key = key; r.rsp_valid = 1'b1;
            r.chk_hit = m.chk_hit; r.hit = m.hit; r.chk_side = m.chk_side; r.side = m.side;
            r.chk_status = 1'b1; r.status = m.status;
            exp_q.push_back(r);
        end
        @(posedge clk);
        #2 bus.req_valid_i = 1'b0;
        repeat (m.lat + hold - 1) @(posedge clk);
        #2 bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #2 bus.rsp_ready_i = 1'b0;
        if (op == 1'b0) begin
            exp_lookups++;
            if (m.hit) exp_hits++;
        end else begin
            exp_inserts++;
        end
        if (m.status == 2'd2 || m.status == 2'd3) exp_fails++;
    endtask

    // Insert into empty banks, then reset while the right bank is being probed.
    task automatic applyMidReset(input logic [63:0] key);
        rec_t r;
        l_hit_i = 1'b0; l_valid_i = 1'b0; l_tag_i = 12'd0;
        r_hit_i = 1'b0; r_valid_i = 1'b0; r_tag_i = 12'd0;
        bus.req_valid_i = 1'b1; bus.req_op_i = 1'b1; bus.req_key_i = key;
        r = '0; r.req_ready = 1'b1;
        exp_q.push_back(r);
        r = '0; r.chk_key = 1'b1; r.key = key; r.l_read = 1'b1;
        exp_q.push_back(r);
        r = '0;
        exp_q.push_back(r);
        r = '0; r.chk_key = 1'b1; r.key = 64'd0;
        exp_q.push_back(r);
        r = '0; r.req_ready = 1'b1; r.chk_key = 1'b1; r.key = 64'd0;
        r.chk_hit = 1'b1; r.chk_side = 1'b1; r.chk_status = 1'b1;
        exp_q.push_back(r);
        @(posedge clk);
        #2 bus.req_valid_i = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        exp_lookups = 0; exp_hits = 0; exp_inserts = 0; exp_fails = 0;
        @(posedge clk);
        #2;
    endtask

    task automatic checkStats();
`ifdef CUCKOO_CTRL_STATS_EN
        checkOutput("stat_lookups", 64'(stat_lookups_o), 64'(exp_lookups));
        checkOutput("stat_hits", 64'(stat_hits_o), 64'(exp_hits));
        checkOutput("stat_inserts", 64'(stat_inserts_o), 64'(exp_inserts));
        checkOutput("stat_fails", 64'(stat_fails_o), 64'(exp_fails));
`endif
    endtask

    initial begin
        #200000;
        errors++;
        $display("[TB] FAIL timeout: simulation did not complete, got hang, expected finish");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        model_t m;
        rec_t   r;
        logic        op, lh, lv, rh, rv;
        logic [11:0] lt, rt;
        logic [63:0] key;

        rst = 1'b1;
        bus.req_valid_i = 1'b0; bus.req_op_i = 1'b0; bus.req_key_i = '0; bus.rsp_ready_i = 1'b0;
        l_hit_i = 1'b0; l_valid_i = 1'b0; l_tag_i = '0;
        r_hit_i = 1'b0; r_valid_i = 1'b0; r_tag_i = '0;
        for (int i = 0; i < 3; i++) begin
            r = '0; r.chk_key = 1'b1; r.key = 64'd0;
            r.chk_hit = 1'b1; r.chk_side = 1'b1; r.chk_status = 1'b1;
            exp_q.push_back(r);
        end
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        checkStats();

        applyStimulus(1'b1, 64'h1040, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 0, m);
        checkOutput("pin_insert_lat", 64'(m.lat), 64'd4);
        checkOutput("pin_insert_wl", 64'(m.wl), 64'd1);

        applyStimulus(1'b0, 64'h1040, 1'b1, 1'b1, 12'h041, 1'b1, 1'b1, 12'h041, 0, m);
        checkOutput("pin_lookup_lat", 64'(m.lat), 64'd2);
        checkOutput("pin_lookup_hit", 64'(m.hit), 64'd1);

        applyStimulus(1'b1, 64'h2080, 1'b0, 1'b1, 12'h005, 1'b0, 1'b1, 12'h007, 0, m);
        checkOutput("pin_full_status", 64'(m.status), 64'd2);
        checkOutput("pin_full_lat", 64'(m.lat), 64'd3);

        applyStimulus(1'b1, 64'h2080, 1'b0, 1'b1, 12'h005, 1'b0, 1'b1, 12'h000, 0, m);
        checkOutput("pin_right_write", 64'(m.wr), 64'd1);
        checkOutput("pin_right_side", 64'(m.side), 64'd1);

        applyStimulus(1'b1, 64'h003F, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 12'h000, 0, m);
        checkOutput("pin_badkey_status", 64'(m.status), 64'd3);
        checkOutput("pin_badkey_lat", 64'(m.lat), 64'd2);

        applyStimulus(1'b1, 64'h30C0, 1'b0, 1'b1, 12'h000, 1'b1, 1'b1, 12'h0C3, 0, m);
        checkOutput("pin_dup_status", 64'(m.status), 64'd1);

        applyStimulus(1'b0, 64'h4100, 1'b1, 1'b0, 12'h104, 1'b1, 1'b1, 12'h104, 5, m);
        applyStimulus(1'b0, 64'h003F, 1'b0, 1'b1, 12'h000, 1'b1, 1'b1, 12'h000, 1, m);
        checkOutput("pin_zero_tag_lookup_lat", 64'(m.lat), 64'd3);

        for (int n = 0; n < 60; n++) begin
            op  = 1'($urandom_range(0, 1));
            key = {$urandom, $urandom};
            if ($urandom_range(0, 4) == 0) key = key & ~(64'hFFF << 6);
            lh  = 1'($urandom_range(0, 3) == 0);
            lv  = 1'($urandom_range(0, 3) != 0);
            rh  = 1'($urandom_range(0, 3) == 0);
            rv  = 1'($urandom_range(0, 3) != 0);
            lt  = ($urandom_range(0, 2) == 0) ? 12'd0 : 12'($urandom);
            rt  = ($urandom_range(0, 2) == 0) ? 12'd0 : 12'($urandom);
            applyStimulus(op, key, lh, lv, lt, rh, rv, rt, int'($urandom_range(0, 2)), m);
        end
        checkStats();

        applyMidReset(64'h5140);
        checkStats();
        applyStimulus(1'b1, 64'h5140, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 0, m);
        checkStats();

        repeat (2) @(posedge clk);
        checkOutput("trace_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
